// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Imported by pc_register and if_fetch_stage.
package if_fetch_stage_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
  localparam logic [ADDR_W-1:0]  PC_INC    = 32'd4;

  // Contents of the IF/ID pipeline register
  typedef struct packed {
    logic [ADDR_W-1:0]  pc_plus4;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } ifid_t;

  // Force a byte address onto a word boundary
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~(ADDR_W'(3));
  endfunction

endpackage : if_fetch_stage_pkg

// File: rtl/if_fetch_stage_pc_register.sv
// Program counter: redirect load beats hold, hold beats sequential advance.
// PC is always word aligned; PC+4 wraps modulo 2^32.
module pc_register
  import if_fetch_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
);

  localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = word_align(RESET_PC);

  assign pc_plus4 = pc + PC_INC;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC_ALIGNED;
    end else if (load) begin
      pc <= word_align(load_addr);
    end else if (!hold) begin
      pc <= pc_plus4;
    end
  end

endmodule : pc_register

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, IF/ID register and fetch counter.
// Optional macro IF_BRANCH_FLUSH_EN squashes the fetch on a redirect edge.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                IMEM_WORDS = 201
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out,
  output logic               fetch_oob
);

  localparam logic [ADDR_W-1:0] IMEM_WORDS_W = ADDR_W'(IMEM_WORDS);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  ifid_t             ifid_q;
  ifid_t             ifid_d;
  ifid_t             fetched;
  logic              ifid_we;
  logic [31:0]       fetch_count;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk       (clk),
    .rst       (rst),
    .hold      (freeze),
    .load      (branch_taken),
    .load_addr (branch_addr),
    .pc        (pc),
    .pc_plus4  (pc_plus4)
  );

  assign imem_addr = pc;
  assign fetch_oob = (pc >> 2) >= IMEM_WORDS_W;

  // NOTE: every signal written here gets a default first, so no path
  // through the block can leave a value unassigned and infer a latch.
  always_comb begin
    fetched = '{pc_plus4: pc_plus4,
                instr:    fetch_oob ? NOP_INSTR : imem_data,
                valid:    !fetch_oob};
    ifid_d  = ifid_q;
    ifid_we = 1'b0;
`ifdef IF_BRANCH_FLUSH_EN
    if (branch_taken) begin
      // Squash the wrong-path word; pc_out keeps its previous value
      ifid_d  = '{pc_plus4: ifid_q.pc_plus4, instr: NOP_INSTR, valid: 1'b0};
      ifid_we = 1'b1;
    end else if (!freeze) begin
      ifid_d  = fetched;
      ifid_we = 1'b1;
    end
`else
    // Branch shadow is padded by software, so the redirect edge loads normally
    if (branch_taken || !freeze) begin
      ifid_d  = fetched;
      ifid_we = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_q      <= '{pc_plus4: '0, instr: NOP_INSTR, valid: 1'b0};
      fetch_count <= '0;
    end else begin
      ifid_q <= ifid_d;
      if (ifid_we && ifid_d.valid) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  assign pc_out    = ifid_q.pc_plus4;
  assign instr_out = ifid_q.instr;
  assign valid_out = ifid_q.valid;

endmodule : if_fetch_stage

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a reference model pushes the expected
// state after each edge, a monitor pops and compares on the falling edge.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          IMEM_WORDS = 201;
  localparam logic [31:0] GARBAGE    = 32'hBAD0_0BAD;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;
  logic        fetch_oob;

  logic [31:0] mem [IMEM_WORDS];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_out;
    logic [31:0] instr;
    logic        valid;
    logic        oob;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  bit started  = 0;
  bit finished = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_pc_out;
  logic [31:0] m_instr;
  logic        m_valid;
  logic [31:0] m_cnt;

  if_fetch_stage #(
    .RESET_PC   (RESET_PC),
    .IMEM_WORDS (IMEM_WORDS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .pc_out       (pc_out),
    .instr_out    (instr_out),
    .valid_out    (valid_out),
    .fetch_oob    (fetch_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> 2;
    if (idx < 32'(IMEM_WORDS)) return mem[int'(idx)];
    return GARBAGE;
  endfunction

  // Instruction memory outside the model's range returns junk the DUT must drop
  assign imem_data = mem_read(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: computes the fetch stage's behaviour from its rules
  initial begin
    forever begin
      logic [31:0] old_pc;
      logic        in_range;
      logic [31:0] word;
      @(posedge clk);
      if (!rst) begin
        m_pc = RESET_PC & ~32'h3;
        m_pc_out = 32'h0;
        m_instr = 32'h0;
        m_valid = 1'b0;
        m_cnt = 32'h0;
      end else begin
        old_pc   = m_pc;
        in_range = (old_pc / 4) < 32'(IMEM_WORDS);
        word     = in_range ? mem[int'(old_pc / 4)] : 32'h0;
        if (branch_taken) begin
`ifdef IF_BRANCH_FLUSH_EN
          m_instr = 32'h0;
          m_valid = 1'b0;
`else
          m_pc_out = old_pc + 32'd4;
          m_instr  = word;
          m_valid  = in_range;
          if (in_range) m_cnt = m_cnt + 32'd1;
`endif
          m_pc = branch_addr & ~32'h3;
        end else if (!freeze) begin
          m_pc_out = old_pc + 32'd4;
          m_instr  = word;
          m_valid  = in_range;
          if (in_range) m_cnt = m_cnt + 32'd1;
          m_pc = old_pc + 32'd4;
        end
      end
      exp_q.push_back('{pc: m_pc, pc_out: m_pc_out, instr: m_instr, valid: m_valid,
                        oob: (m_pc / 4) >= 32'(IMEM_WORDS), cnt: m_cnt});
      started = 1'b1;
    end
  end

  // Monitor: compares the DUT against the oldest expectation each falling edge
  always @(negedge clk) begin
    exp_t e;
    if (started && !finished) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("imem_addr",   imem_addr,         e.pc);
        check("pc_out",      pc_out,            e.pc_out);
        check("instr_out",   instr_out,         e.instr);
        check("valid_out",   32'(valid_out),    32'(e.valid));
        check("fetch_oob",   32'(fetch_oob),    32'(e.oob));
        check("fetch_count", dut.fetch_count,   e.cnt);
      end
    end
  end

  // Inputs change 1 time unit after the falling edge, clear of both edges
  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  task automatic wait_pc(input logic [31:0] target);
    for (int i = 0; i < 64; i++) begin
      if (m_pc == target) return;
      cycle();
    end
    check("wait_pc_timeout", m_pc, target);
  endtask

  initial begin
    rst = 1'b0;
    freeze = 1'b0;
    branch_taken = 1'b0;
    branch_addr = 32'h0;
    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;

    // Straight-line fetch of words A, B, C, D
    repeat (3) cycle();
    rst = 1'b1;
    repeat (6) cycle();

    // Three-cycle freeze with PC at 8
    do_reset();
    wait_pc(32'h8);
    freeze = 1'b1;
    repeat (3) cycle();
    freeze = 1'b0;
    repeat (3) cycle();

    // Redirect to an unaligned target from PC 16
    do_reset();
    wait_pc(32'h10);
    branch_taken = 1'b1;
    branch_addr  = 32'h0000_0029;
    cycle();
    branch_taken = 1'b0;
    repeat (2) cycle();

    // Redirect wins over a simultaneous freeze
    do_reset();
    wait_pc(32'h8);
    branch_taken = 1'b1;
    freeze       = 1'b1;
    branch_addr  = 32'h40;
    cycle();
    branch_taken = 1'b0;
    freeze       = 1'b0;
    repeat (2) cycle();

    // Target one word past the end of memory
    branch_taken = 1'b1;
    branch_addr  = 32'(4 * IMEM_WORDS);
    cycle();
    branch_taken = 1'b0;
    repeat (2) cycle();

    // PC wrap from the top of the address space
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    cycle();
    branch_taken = 1'b0;
    repeat (3) cycle();

    // Asynchronous reset during a freeze with a redirect pending
    do_reset();
    wait_pc(32'h20);
    freeze = 1'b1;
    repeat (2) cycle();
    #2;
    rst          = 1'b0;
    branch_taken = 1'b1;
    branch_addr  = 32'h80;
    #1;
    check("async_rst_imem_addr",   imem_addr,        RESET_PC);
    check("async_rst_instr_out",   instr_out,        32'h0);
    check("async_rst_pc_out",      pc_out,           32'h0);
    check("async_rst_valid_out",   32'(valid_out),   32'h0);
    check("async_rst_fetch_count", dut.fetch_count,  32'h0);
    repeat (2) cycle();
    branch_taken = 1'b0;
    freeze       = 1'b0;
    rst          = 1'b1;
    repeat (4) cycle();

    // Randomised mix of stalls, redirects and occasional resets
    for (int i = 0; i < 500; i++) begin
      rst          = ($urandom_range(0, 99) != 0);
      freeze       = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       branch_addr = 32'($urandom_range(0, 4 * IMEM_WORDS + 16));
        1:       branch_addr = $urandom;
        2:       branch_addr = 32'($urandom_range(0, 4 * IMEM_WORDS - 1));
        default: branch_addr = 32'(4 * IMEM_WORDS - 4);
      endcase
      cycle();
    end

    rst          = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    repeat (3) cycle();
    finished = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_if_fetch_stage
